// File: rtl/jtpopeye_obj_pkg.sv
// Shared definitions for the object line renderer: FSM state encoding,
// default parameter values and the ROM word geometry helper.
package jtpopeye_obj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2
  } obj_state_t;

  localparam int DEF_CW   = 3;
  localparam int DEF_PW   = 2;
  localparam int DEF_HW   = 8;
  localparam int DEF_AW   = 13;
  localparam int DEF_NOBJ = 16;
  localparam int ROM_DW   = 32;

  // Number of pixels packed in one ROM word for a given pixel width
  function automatic int pix_per_word(input int pw);
    return ROM_DW / pw;
  endfunction

endpackage

// File: rtl/jtpopeye_obj_linebuf.sv
// Double-buffered object line buffer. The bank selected by draw_bank takes
// draw writes; the other bank is read at scan_addr and cleared at the same
// location in the same cycle (read-first), so it is blank when it next
// becomes the draw bank.
module jtpopeye_obj_linebuf #(
  parameter int HW = 8,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          draw_bank,
  input  logic          draw_we,
  input  logic [HW-1:0] draw_addr,
  input  logic [DW-1:0] draw_data,
  input  logic [HW-1:0] scan_addr,
  output logic [DW-1:0] scan_data
);

  localparam int LEN = 1 << HW;

  logic out_bank_reg;
  logic out_en_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [DW-1:0] mem [LEN];
      logic [DW-1:0] rd_reg;
      logic          is_draw;
      logic          we;
      logic [HW-1:0] wa;
      logic [DW-1:0] wd;

      // Each bank owns one write port: draw data when drawing, zero when scanning
      assign is_draw = (draw_bank == 1'(gi));
      assign we      = cen & (is_draw ? draw_we : 1'b1);
      assign wa      = is_draw ? draw_addr : scan_addr;
      assign wd      = is_draw ? draw_data : '0;

      // Write port plus registered read (old data returned on clear-behind)
      always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (cen) rd_reg <= mem[scan_addr];
      end
    end
  endgenerate

  // Track which bank the registered read belongs to; blank output until first read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_bank_reg <= 1'b1;
      out_en_reg   <= 1'b0;
    end else if (cen) begin
      out_bank_reg <= ~draw_bank;
      out_en_reg   <= 1'b1;
    end
  end

  assign scan_data = !out_en_reg  ? '0 :
                     out_bank_reg ? g_bank[1].rd_reg : g_bank[0].rd_reg;

endmodule

// File: rtl/jtpopeye_objdraw.sv
// Object line renderer: accepts object entries, fetches each 32-bit ROM row
// over a cs/ok handshake, and draws non-transparent pixels into the draw
// bank of a double-buffered line buffer while the other bank is scanned out.
// Optional feature macro: JTPOPEYE_OBJ_HFLIP_EN enables horizontal flip.
module jtpopeye_objdraw
  import jtpopeye_obj_pkg::*;
#(
  parameter int CW   = DEF_CW,
  parameter int PW   = DEF_PW,
  parameter int HW   = DEF_HW,
  parameter int AW   = DEF_AW,
  parameter int NOBJ = DEF_NOBJ
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          line_start,
  input  logic [HW-1:0] H,
  input  logic          obj_valid,
  output logic          obj_ready,
  input  logic [HW-1:0] obj_x,
  input  logic [CW-1:0] obj_pal,
  input  logic [AW-1:0] obj_addr,
  input  logic          obj_hflip,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [31:0]   rom_data,
  output logic [CW-1:0] OBJC,
  output logic [PW-1:0] OBJV,
  output logic          overflow
);

  localparam int NPIX = pix_per_word(PW);
  localparam int KW   = $clog2(NPIX);
  localparam int CNTW = $clog2(NOBJ + 1) + 1;

  obj_state_t    state_reg, state_next;
  logic          bank_reg, bank_next;
  logic [CNTW-1:0] cnt_reg, cnt_next, cnt_base;
  logic          overflow_reg, overflow_next;
  logic          ready_reg, ready_next;
  logic          cs_reg, cs_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [HW-1:0] x_reg, x_next;
  logic [CW-1:0] pal_reg, pal_next;
  logic          hflip_reg, hflip_next;
  logic [31:0]   data_reg, data_next;
  logic [KW-1:0] k_reg, k_next;

  logic          transfer;
  logic [KW-1:0] pix_idx;
  logic [PW-1:0] pix;
  logic          draw_we;
  logic [HW-1:0] draw_addr;

  assign transfer  = cen & obj_valid & ready_reg;
  assign pix_idx   = hflip_reg ? (KW'(NPIX - 1) - k_reg) : k_reg;
  assign pix       = data_reg[PW*pix_idx +: PW];
  assign draw_addr = x_reg + HW'(k_reg);
  assign cnt_base  = line_start ? '0 : cnt_reg;

`ifdef JTPOPEYE_OBJ_HFLIP_EN
  wire hflip_in = obj_hflip;
`else
  wire hflip_in = 1'b0;
  wire unused_hflip = obj_hflip;
`endif

  // Next-state logic: line swap, entry accept, ROM fetch and pixel drawing
  always_comb begin
    state_next    = state_reg;
    bank_next     = bank_reg;
    cnt_next      = cnt_reg;
    overflow_next = overflow_reg;
    addr_next     = addr_reg;
    x_next        = x_reg;
    pal_next      = pal_reg;
    hflip_next    = hflip_reg;
    data_next     = data_reg;
    k_next        = k_reg;
    draw_we       = 1'b0;
    if (cen) begin
      if (line_start) begin
        // New line: swap banks and abort any fetch/draw in flight
        bank_next     = ~bank_reg;
        cnt_next      = '0;
        overflow_next = 1'b0;
        state_next    = ST_IDLE;
      end
      if (transfer) begin
        // Entry coinciding with line_start counts toward the new line
        x_next     = obj_x;
        pal_next   = obj_pal;
        hflip_next = hflip_in;
        if (cnt_base < CNTW'(NOBJ)) begin
          cnt_next   = cnt_base + 1'b1;
          addr_next  = obj_addr;
          state_next = ST_FETCH;
        end else begin
          overflow_next = 1'b1;
        end
      end else if (!line_start) begin
        case (state_reg)
          ST_FETCH: if (rom_ok) begin
            data_next  = rom_data;
            k_next     = '0;
            state_next = ST_DRAW;
          end
          ST_DRAW: begin
            draw_we = (pix != '0);
            k_next  = k_reg + 1'b1;
            if (k_reg == KW'(NPIX - 1)) state_next = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
    ready_next = (state_next == ST_IDLE);
    cs_next    = (state_next == ST_FETCH);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      bank_reg     <= 1'b0;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
      ready_reg    <= 1'b1;
      cs_reg       <= 1'b0;
      addr_reg     <= '0;
      x_reg        <= '0;
      pal_reg      <= '0;
      hflip_reg    <= 1'b0;
      data_reg     <= '0;
      k_reg        <= '0;
    end else begin
      state_reg    <= state_next;
      bank_reg     <= bank_next;
      cnt_reg      <= cnt_next;
      overflow_reg <= overflow_next;
      ready_reg    <= ready_next;
      cs_reg       <= cs_next;
      addr_reg     <= addr_next;
      x_reg        <= x_next;
      pal_reg      <= pal_next;
      hflip_reg    <= hflip_next;
      data_reg     <= data_next;
      k_reg        <= k_next;
    end
  end

  assign obj_ready = ready_reg;
  assign rom_cs    = cs_reg;
  assign rom_addr  = addr_reg;
  assign overflow  = overflow_reg;

  jtpopeye_obj_linebuf #(
    .HW (HW),
    .DW (CW + PW)
  ) u_linebuf (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .draw_bank (bank_reg),
    .draw_we   (draw_we),
    .draw_addr (draw_addr),
    .draw_data ({pal_reg, pix}),
    .scan_addr (H),
    .scan_data ({OBJC, OBJV})
  );

endmodule

// File: tb/tb_jtpopeye_objdraw.sv
// Self-checking bench for jtpopeye_objdraw: directed and random object lines
// checked pixel by pixel against a behavioural two-bank line model.
module tb_jtpopeye_objdraw;

  localparam int CW = 3, PW = 2, HW = 8, AW = 13, NOBJ = 16;
`ifdef JTPOPEYE_OBJ_HFLIP_EN
  localparam bit HFEN = 1'b1;
`else
  localparam bit HFEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, cen, line_start, obj_valid, obj_hflip, rom_ok;
  logic [HW-1:0] H, obj_x;
  logic [CW-1:0] obj_pal;
  logic [AW-1:0] obj_addr;
  logic [31:0]   rom_data;
  logic          obj_ready, rom_cs, overflow;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] OBJC;
  logic [PW-1:0] OBJV;

  always #5 clk = ~clk;

  jtpopeye_objdraw #(.CW(CW), .PW(PW), .HW(HW), .AW(AW), .NOBJ(NOBJ)) dut (
    .clk(clk), .rst(rst), .cen(cen), .line_start(line_start), .H(H),
    .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_x(obj_x),
    .obj_pal(obj_pal), .obj_addr(obj_addr), .obj_hflip(obj_hflip),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .OBJC(OBJC), .OBJV(OBJV), .overflow(overflow)
  );

  int nvec = 0;
  int errs = 0;
  int model [2][256];   // expected {pal,pix} per bank and position
  int draw_b = 0;       // bank currently being drawn
  int cnt_m  = 0;       // entries offered this line
  bit ovf_m  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the scanned bank is cleared at H as the beam passes
  task automatic tick();
    model[1-draw_b][int'(H)] = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_line_start();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    draw_b = 1 - draw_b;
    cnt_m  = 0;
    ovf_m  = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'(0));
  endtask

  task automatic sweep(input bit check);
    for (int h = 0; h < 256; h++) begin
      int exp;
      H   = 8'(h);
      exp = model[1-draw_b][h];
      tick();
      if (check) chk($sformatf("scan_h%02h", h), 32'({OBJC, OBJV}), 32'(exp));
    end
  endtask

  task automatic model_draw(input int x, input int pal, input bit hf, input logic [31:0] data);
    for (int k = 0; k < 16; k++) begin
      int idx, pix;
      idx = (HFEN && hf) ? 15 - k : k;
      pix = int'((data >> (2 * idx)) & 32'd3);
      if (pix != 0) model[draw_b][(x + k) % 256] = pal * 4 + pix;
    end
  endtask

  task automatic feed(input int x, input int pal, input int addr, input bit hf,
                      input logic [31:0] data, input int delay);
    int n;
    n = 0;
    while (!obj_ready && n < 40) begin tick(); n++; end
    chk("ready_wait", 32'(obj_ready), 32'(1));
    obj_valid = 1'b1; obj_x = 8'(x); obj_pal = 3'(pal);
    obj_addr = 13'(addr); obj_hflip = hf;
    tick();
    obj_valid = 1'b0;
    cnt_m++;
    if (cnt_m > NOBJ) begin
      ovf_m = 1'b1;
      chk("ovf_set", 32'(overflow), 32'(1));
      chk("ovf_ready", 32'(obj_ready), 32'(1));
      chk("ovf_no_cs", 32'(rom_cs), 32'(0));
      return;
    end
    chk("acc_ready_low", 32'(obj_ready), 32'(0));
    chk("fetch_cs", 32'(rom_cs), 32'(1));
    chk("fetch_addr", 32'(rom_addr), 32'(addr));
    repeat (delay) tick();
    chk("cs_hold", 32'(rom_cs), 32'(1));
    chk("addr_hold", 32'(rom_addr), 32'(addr));
    rom_ok = 1'b1; rom_data = data;
    tick();
    rom_ok = 1'b0; rom_data = $urandom;
    n = 0;
    while (!obj_ready && n < 40) begin tick(); n++; end
    chk("draw_cycles", 32'(n), 32'(16));
    chk("ovf_low", 32'(overflow), 32'(ovf_m));
    model_draw(x, pal, hf, data);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; line_start = 1'b0; H = '0;
    obj_valid = 1'b0; obj_x = '0; obj_pal = '0; obj_addr = '0; obj_hflip = 1'b0;
    rom_ok = 1'b0; rom_data = '0;
    for (int b = 0; b < 2; b++) for (int a = 0; a < 256; a++) model[b][a] = 0;
    #12;
    chk("rst_ready", 32'(obj_ready), 32'(1));
    chk("rst_cs", 32'(rom_cs), 32'(0));
    chk("rst_addr", 32'(rom_addr), 32'(0));
    chk("rst_objc", 32'(OBJC), 32'(0));
    chk("rst_objv", 32'(OBJV), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Flush power-up garbage from both banks
    sweep(1'b0); do_line_start(); sweep(1'b0); do_line_start();

    // Single pixel, no flip; second pass checks clear-behind
    feed(8'h10, 5, 13'h0123, 1'b0, 32'h0000_0001, 1);
    do_line_start(); sweep(1'b1); sweep(1'b1);

    // Same object with hflip
    feed(8'h10, 5, 13'h0124, 1'b1, 32'h0000_0001, 0);
    do_line_start(); sweep(1'b1);

    // Wrap around the line end
    feed(8'hF8, 6, 13'h1FFF, 1'b0, 32'hFFFF_FFFF, 2);
    do_line_start(); sweep(1'b1);

    // Overlap: last entry wins, transparent pixels let earlier ones show
    feed(8'h40, 1, 13'h0010, 1'b0, $urandom, 0);
    feed(8'h40, 2, 13'h0011, 1'b0, 32'hAAAA_AAAA, 3);
    do_line_start(); sweep(1'b1);
    feed(8'h40, 1, 13'h0012, 1'b0, 32'h5555_5555, 1);
    feed(8'h40, 2, 13'h0013, 1'b0, 32'h0000_0000, 0);
    do_line_start(); sweep(1'b1);

    // 17 entries: last one discarded, overflow until line_start
    for (int i = 0; i < NOBJ + 1; i++)
      feed($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 8191),
           1'($urandom), $urandom, $urandom_range(0, 2));
    chk("ovf_17", 32'(overflow), 32'(1));
    do_line_start(); sweep(1'b1);

    // Abort a fetch with line_start; late rom_ok must be ignored
    obj_valid = 1'b1; obj_x = 8'h20; obj_pal = 3'd7; obj_addr = 13'h0AAA; obj_hflip = 1'b0;
    tick();
    obj_valid = 1'b0; cnt_m++;
    chk("abort_cs", 32'(rom_cs), 32'(1));
    tick();
    do_line_start();
    chk("abort_cs_drop", 32'(rom_cs), 32'(0));
    chk("abort_ready", 32'(obj_ready), 32'(1));
    tick(); tick();
    rom_ok = 1'b1; rom_data = 32'hFFFF_FFFF;
    tick();
    rom_ok = 1'b0;
    tick(); tick();
    chk("late_ok_ready", 32'(obj_ready), 32'(1));
    chk("late_ok_cs", 32'(rom_cs), 32'(0));
    do_line_start(); sweep(1'b1);
    do_line_start(); sweep(1'b1); sweep(1'b1);

    // Random lines
    for (int l = 0; l < 4; l++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        feed($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 8191),
             1'($urandom), $urandom, $urandom_range(0, 3));
      do_line_start(); sweep(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
